// File: rtl/jk_pkg.sv
// Shared definitions for the JK-based counters: direction encoding, the
// J/K drive pair type and the helper that derives a cell's drive from its
// current and next state.
package jk_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drive_t;

  // Set when going 0->1, reset when going 1->0, hold otherwise; the
  // toggle combination (11) can never come out of this.
  function automatic jk_drive_t jk_drive(input logic cur, input logic nxt);
    jk_drive_t d;
    d.j = nxt & ~cur;
    d.k = ~nxt & cur;
    return d;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One-bit JK storage cell with true and complemented outputs.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_n
);

  // JK state update: 00 hold, 01 reset, 10 set, 11 toggle.
  // NOTE: state is written with <= so every cell samples the pre-edge
  // value of its neighbours; = here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_n = ~q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter built from per-bit JK cells.
// Priority per edge: load > en > hold. Load values at or above MODULUS
// clamp to MODULUS-1.
// Optional build macro JK_CNT_SATURATE_EN: counting saturates at the ends
// of the range instead of wrapping, and wrap stays low.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             wrap
);

  // One extra bit keeps MODULUS == 2**WIDTH representable in comparisons.
  localparam logic [WIDTH:0]   MOD_LIM = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   LAST    = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE     = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   next_ext;
  logic             wrap_next;
  logic             next_msb_unused;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  assign cur_ext = {1'b0, q};

  // Next-state selection and wrap detection.
  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    next_ext  = cur_ext;
    wrap_next = 1'b0;
    if (load) begin
      if ({1'b0, load_val} >= MOD_LIM) next_ext = LAST;
      else                             next_ext = {1'b0, load_val};
    end else if (en) begin
      if (up == DIR_UP) begin
        if (cur_ext == LAST) begin
`ifdef JK_CNT_SATURATE_EN
          next_ext = LAST;
`else
          next_ext  = '0;
          wrap_next = 1'b1;
`endif
        end else begin
          next_ext = cur_ext + ONE;
        end
      end else if (up == DIR_DOWN) begin
        if (cur_ext == '0) begin
`ifdef JK_CNT_SATURATE_EN
          next_ext = '0;
`else
          next_ext  = LAST;
          wrap_next = 1'b1;
`endif
        end else begin
          next_ext = cur_ext - ONE;
        end
      end
    end
  end

  // Next state is always below MODULUS, so the extension bit is always 0.
  assign next_msb_unused = next_ext[WIDTH];

  // Per-bit JK drive and storage.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_drive_t drv;
    assign drv      = jk_drive(q[i], next_ext[i]);
    assign j_vec[i] = drv.j;
    assign k_vec[i] = drv.k;

    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (drv.j),
      .k     (drv.k),
      .q     (q[i]),
      .q_n   (q_n[i])
    );
  end

  // Terminal count follows the direction input with no register stage.
  assign tc = (up == DIR_UP) ? (q == LAST_W) : (q == '0);

  // Wrap pulse registered so it lines up with the q update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= wrap_next;
  end

endmodule
